// File: rtl/keypad_debounce.sv
// Keypad debouncer: synchronises 10 digit keys plus '#', debounces a single key
// press and reports it once, flags multi-key presses, and debounces the release.
module keypad_debounce #(
   parameter int unsigned DB_CYCLES = 500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] keypad,
   input  logic       sharp,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       sharp_pulse,
   output logic       key_held,
   output logic       multi_key
);

   typedef enum logic [1:0] {IDLE, WAIT, HELD, REL} state_t;

   localparam logic [19:0] DB = 20'(DB_CYCLES);

   state_t      state, state_n;
   logic [10:0] s1, s;
   logic [10:0] cap, cap_n;
   logic [19:0] count, count_n, count_inc;
   logic        valid_n, sharp_n, multi_n, held_n;
   logic [3:0]  code_n, enc;
   logic        s_zero, s_onehot;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1          <= '0;
         s           <= '0;
         state       <= REL;
         cap         <= '0;
         count       <= '0;
         key_valid   <= 1'b0;
         sharp_pulse <= 1'b0;
         multi_key   <= 1'b0;
         key_held    <= 1'b0;
         key_code    <= 4'hF;
      end else begin
         s1          <= {sharp, keypad};
         s           <= s1;
         state       <= state_n;
         cap         <= cap_n;
         count       <= count_n;
         key_valid   <= valid_n;
         sharp_pulse <= sharp_n;
         multi_key   <= multi_n;
         key_held    <= held_n;
         key_code    <= code_n;
      end
   end

   assign s_zero    = (s == '0);
   assign s_onehot  = !s_zero && ((s & (s - 11'd1)) == '0);
   assign count_inc = (count == '1) ? count : count + 20'd1;

   // cap is one-hot here, so its bit index is the key code ('#' is bit 10 = 4'hA)
   always_comb begin
      enc = '0;
      for (int unsigned i = 0; i < 11; i++) begin
         if (cap[i]) enc = 4'(i);
      end
   end

   always_comb begin
      state_n = state;
      cap_n   = cap;
      count_n = count;
      valid_n = 1'b0;
      sharp_n = 1'b0;
      multi_n = 1'b0;
      held_n  = key_held;
      code_n  = key_code;
      case (state)
         IDLE: begin
            if (s_onehot) begin
               cap_n   = s;
               count_n = 20'd1;
               state_n = WAIT;
            end else if (!s_zero) begin
               multi_n = 1'b1;
               held_n  = 1'b0;
               state_n = HELD;
            end
         end
         WAIT: begin
            if (s != cap) begin
               count_n = '0;
               state_n = IDLE;
            end else if (count < DB) begin
               count_n = count_inc;
            end else begin
               valid_n = 1'b1;
               sharp_n = cap[10];
               code_n  = enc;
               held_n  = 1'b1;
               state_n = HELD;
            end
         end
         HELD: begin
            if (s_zero) begin
               count_n = 20'd1;
               state_n = REL;
            end
         end
         REL: begin
            // any activity during release restarts the hold, never a new press
            if (!s_zero) begin
               count_n = '0;
               state_n = HELD;
            end else if (count < DB) begin
               count_n = count_inc;
            end else begin
               count_n = '0;
               held_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = REL;
      endcase
   end

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce with DB_CYCLES = 4; inputs change and
// outputs are sampled on the falling clock edge.
module tb_keypad_debounce;

   logic       clock = 1'b0;
   logic       reset;
   logic [9:0] keypad;
   logic       sharp;
   logic       key_valid;
   logic [3:0] key_code;
   logic       sharp_pulse;
   logic       key_held;
   logic       multi_key;

   int total = 0;
   int bad   = 0;
   int t, nvalid, nsharp, nmulti, first_valid, first_multi;
   int held_at [0:63];

   keypad_debounce #(.DB_CYCLES(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .keypad     (keypad),
      .sharp      (sharp),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .sharp_pulse(sharp_pulse),
      .key_held   (key_held),
      .multi_key  (multi_key)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      t = 0; nvalid = 0; nsharp = 0; nmulti = 0; first_valid = 0; first_multi = 0;
   endtask

   // apply {sharp,keypad} for n falling edges, tallying pulses per tick index
   task automatic run(input logic [10:0] v, input int n);
      {sharp, keypad} = v;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         t++;
         if (t < 64) held_at[t] = int'(key_held);
         if (key_valid) begin
            nvalid++;
            if (first_valid == 0) first_valid = t;
         end
         if (sharp_pulse) begin
            nsharp++;
            if (!key_valid) nsharp += 100;
         end
         if (multi_key) begin
            nmulti++;
            if (first_multi == 0) first_multi = t;
         end
      end
   endtask

   initial begin
      reset = 1'b1; keypad = '0; sharp = 1'b0;
      clr();
      repeat (2) @(negedge clock);
      check("rst_valid", 32'(key_valid), 0);
      check("rst_sharp", 32'(sharp_pulse), 0);
      check("rst_multi", 32'(multi_key), 0);
      check("rst_held", 32'(key_held), 0);
      check("rst_code", 32'(key_code), 32'hF);

      // startup idle
      reset = 1'b0;
      clr(); run(11'h000, 10);
      check("start_pulses", 32'(nvalid + nsharp + nmulti), 0);
      check("start_code", 32'(key_code), 32'hF);
      check("start_held", 32'(key_held), 0);

      // clean digit 3
      clr(); run(11'h008, 20);
      check("d3_count", 32'(nvalid), 1);
      check("d3_first", 32'(first_valid), 7);
      check("d3_code", 32'(key_code), 3);
      check("d3_held", 32'(key_held), 1);
      check("d3_nosharp", 32'(nsharp), 0);
      clr(); run(11'h000, 10);
      check("d3_rel_held6", 32'(held_at[6]), 1);
      check("d3_rel_held7", 32'(held_at[7]), 0);

      // bouncing digit 5
      clr();
      run(11'h020, 1); run(11'h000, 1); run(11'h020, 1); run(11'h000, 1);
      run(11'h020, 20);
      check("b5_count", 32'(nvalid), 1);
      check("b5_first", 32'(first_valid), 11);
      check("b5_code", 32'(key_code), 5);
      clr(); run(11'h000, 10);

      // sharp key
      clr(); run(11'h400, 10);
      check("sh_valid", 32'(nvalid), 1);
      check("sh_pulse", 32'(nsharp), 1);
      check("sh_first", 32'(first_valid), 7);
      check("sh_code", 32'(key_code), 32'hA);
      clr(); run(11'h000, 10);

      // multi-key 1+2, then digit 7
      clr(); run(11'h006, 8);
      check("mk_count", 32'(nmulti), 1);
      check("mk_first", 32'(first_multi), 3);
      check("mk_novalid", 32'(nvalid), 0);
      check("mk_code", 32'(key_code), 32'hA);
      check("mk_held", 32'(key_held), 0);
      clr(); run(11'h000, 10);
      check("mk_relquiet", 32'(nvalid + nmulti), 0);
      clr(); run(11'h080, 10);
      check("d7_count", 32'(nvalid), 1);
      check("d7_code", 32'(key_code), 7);
      clr(); run(11'h000, 10);

      // extra key while held
      clr(); run(11'h004, 10); run(11'h104, 10);
      check("ex_count", 32'(nvalid), 1);
      check("ex_multi", 32'(nmulti), 0);
      check("ex_code", 32'(key_code), 2);
      clr(); run(11'h000, 10);

      // release bounce on digit 4
      clr(); run(11'h010, 10);
      check("rb_press", 32'(nvalid), 1);
      clr(); run(11'h000, 2); run(11'h010, 2); run(11'h000, 12);
      check("rb_novalid", 32'(nvalid), 0);
      check("rb_held10", 32'(held_at[10]), 1);
      check("rb_held11", 32'(held_at[11]), 0);
      check("rb_code", 32'(key_code), 4);

      // reset while digit 9 is mid-debounce and held
      clr(); run(11'h200, 4);
      reset = 1'b1; run(11'h200, 1);
      check("rh_code", 32'(key_code), 32'hF);
      check("rh_held", 32'(key_held), 0);
      reset = 1'b0; run(11'h200, 20);
      check("rh_novalid", 32'(nvalid), 0);
      clr(); run(11'h000, 10); run(11'h200, 10);
      check("rh_fresh", 32'(nvalid), 1);
      check("rh_code9", 32'(key_code), 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
